// File: rtl/arcade_input_cond.sv
// Multi-player input conditioner: per-player SOCD direction resolver plus a
// queued coin pulse generator with a guaranteed gap between pulses.

module arcade_input_chan #(
  parameter int SOCD_MODE = 0,
  parameter int CNT_W     = 20,
  parameter int PULSE_LEN = 1048575,
  parameter int GAP_LEN   = 262144
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] dir_raw,
  input  logic       coin_raw,
  output logic [3:0] dir,
  output logic       coin,
  output logic [1:0] pend
);
  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'((GAP_LEN == 0) ? 0 : GAP_LEN - 1);

  logic [3:0]            d1, d2;
  logic                  c1, c2;
  logic [1:0][1:0]       last_q, first_q, last_d, first_d, res;
  logic [1:0]            ax1, ax2, rs;
  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic                  fall, deq;

  // Axis a=0 is horizontal {L,R}, a=1 is vertical {U,D}; bit 1 outranks bit 0.
  always_comb begin
    last_d  = last_q;
    first_d = first_q;
    res     = '0;
    ax1     = '0;
    ax2     = '0;
    rs      = '0;
    for (int a = 0; a < 2; a++) begin
      ax1 = d1[2*a +: 2];
      ax2 = d2[2*a +: 2];
      rs  = ax1 & ~ax2;
      if (rs[1])      last_d[a] = 2'b10;
      else if (rs[0]) last_d[a] = 2'b01;
      // Entering the conflict remembers what was already held (00 if both rose).
      if (ax1 == 2'b11 && ax2 != 2'b11) first_d[a] = ax2;
      if (ax1 != 2'b11) res[a] = ax1;
      else begin
        case (SOCD_MODE)
          0:       res[a] = last_d[a];
          2:       res[a] = first_d[a];
          default: res[a] = 2'b00;
        endcase
      end
    end
  end

  assign fall = c2 & ~c1;
  assign deq  = (state == IDLE) && (pend != 2'd0);
  assign coin = (state == PULSE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      d1      <= '0;
      d2      <= '0;
      c1      <= 1'b0;
      c2      <= 1'b0;
      last_q  <= '0;
      first_q <= '0;
      dir     <= '0;
      pend    <= '0;
      state   <= IDLE;
      cnt     <= '0;
    end else begin
      d1      <= dir_raw;
      d2      <= d1;
      c1      <= coin_raw;
      c2      <= c1;
      last_q  <= last_d;
      first_q <= first_d;
      dir     <= {res[1], res[0]};
      if (fall && !deq)      pend <= (pend == 2'd3) ? 2'd3 : pend + 2'd1;
      else if (!fall && deq) pend <= pend - 2'd1;
      case (state)
        IDLE: if (pend != 2'd0) begin
          state <= PULSE;
          cnt   <= PULSE_LD;
        end
        PULSE: if (cnt == '0) begin
          if (GAP_LEN == 0) state <= IDLE;
          else begin
            state <= GAP;
            cnt   <= GAP_LD;
          end
        end else cnt <= cnt - 1'b1;
        GAP: if (cnt == '0) state <= IDLE;
             else cnt <= cnt - 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

module arcade_input_cond #(
  parameter int PLAYERS   = 2,
  parameter int SOCD_MODE = 0,
  parameter int CNT_W     = 20,
  parameter int PULSE_LEN = 1048575,
  parameter int GAP_LEN   = 262144
) (
  input  logic                 clk,
  input  logic                 I_RESETn,
  input  logic [4*PLAYERS-1:0] I_DIR,
  input  logic [PLAYERS-1:0]   I_COIN,
  output logic [4*PLAYERS-1:0] O_DIR,
  output logic [PLAYERS-1:0]   O_COIN,
  output logic [2*PLAYERS-1:0] O_COIN_PEND
);
  for (genvar p = 0; p < PLAYERS; p++) begin : g_chan
    arcade_input_chan #(
      .SOCD_MODE(SOCD_MODE),
      .CNT_W    (CNT_W),
      .PULSE_LEN(PULSE_LEN),
      .GAP_LEN  (GAP_LEN)
    ) u_chan (
      .clk     (clk),
      .reset_n (I_RESETn),
      .dir_raw (I_DIR[4*p +: 4]),
      .coin_raw(I_COIN[p]),
      .dir     (O_DIR[4*p +: 4]),
      .coin    (O_COIN[p]),
      .pend    (O_COIN_PEND[2*p +: 2])
    );
  end
endmodule

// File: tb/tb_arcade_input_cond.sv
// Directed bench for arcade_input_cond: SOCD modes, coin queue timing, reset
// and multi-channel independence, using several differently parameterised copies.

module tb_arcade_input_cond;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  dir_m0 = '0, odir_m0;
  logic        coin_m0 = 1'b0, ocoin_m0;
  logic [1:0]  pend_m0;
  logic [7:0]  dir2 = '0, odir_m1, odir_m2;
  logic [1:0]  coin2 = '0, ocoin_m1, ocoin_m2;
  logic [3:0]  pend_m1, pend_m2;
  logic [3:0]  dir_g0 = '0, odir_g0;
  logic        coin_g0 = 1'b0, ocoin_g0;
  logic [1:0]  pend_g0;
  logic [15:0] dir_p4 = '0, odir_p4;
  logic [3:0]  coin_p4 = '0, ocoin_p4;
  logic [7:0]  pend_p4;

  arcade_input_cond #(.PLAYERS(1), .SOCD_MODE(0), .CNT_W(4), .PULSE_LEN(8), .GAP_LEN(4)) u_m0 (
    .clk(clk), .I_RESETn(rst_n), .I_DIR(dir_m0), .I_COIN(coin_m0),
    .O_DIR(odir_m0), .O_COIN(ocoin_m0), .O_COIN_PEND(pend_m0));
  arcade_input_cond #(.PLAYERS(2), .SOCD_MODE(1), .CNT_W(4), .PULSE_LEN(8), .GAP_LEN(4)) u_m1 (
    .clk(clk), .I_RESETn(rst_n), .I_DIR(dir2), .I_COIN(coin2),
    .O_DIR(odir_m1), .O_COIN(ocoin_m1), .O_COIN_PEND(pend_m1));
  arcade_input_cond #(.PLAYERS(2), .SOCD_MODE(2), .CNT_W(4), .PULSE_LEN(8), .GAP_LEN(4)) u_m2 (
    .clk(clk), .I_RESETn(rst_n), .I_DIR(dir2), .I_COIN(coin2),
    .O_DIR(odir_m2), .O_COIN(ocoin_m2), .O_COIN_PEND(pend_m2));
  arcade_input_cond #(.PLAYERS(1), .SOCD_MODE(0), .CNT_W(4), .PULSE_LEN(8), .GAP_LEN(0)) u_g0 (
    .clk(clk), .I_RESETn(rst_n), .I_DIR(dir_g0), .I_COIN(coin_g0),
    .O_DIR(odir_g0), .O_COIN(ocoin_g0), .O_COIN_PEND(pend_g0));
  arcade_input_cond #(.PLAYERS(4), .SOCD_MODE(0), .CNT_W(4), .PULSE_LEN(8), .GAP_LEN(4)) u_p4 (
    .clk(clk), .I_RESETn(rst_n), .I_DIR(dir_p4), .I_COIN(coin_p4),
    .O_DIR(odir_p4), .O_COIN(ocoin_p4), .O_COIN_PEND(pend_p4));

  int n_chk = 0, n_pass = 0;
  logic [5:0] tr [256];   // {p4 coins, g0 coin, m0 coin} per cycle
  int nrec = 0;
  logic rec = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    if (rec && nrec < 256) begin
      tr[nrec] = {ocoin_p4, ocoin_g0, ocoin_m0};
      nrec++;
    end
  endtask

  // Pulse count, every high length and every low gap between pulses.
  task automatic analyze(input string tag, input int idx, input int exp_n,
                         input int exp_hi, input int exp_gap);
    int n, hi, lo;
    logic prev, b;
    n = 0; hi = 0; lo = 0; prev = 1'b0;
    for (int i = 0; i < nrec; i++) begin
      b = tr[i][idx];
      if (b && !prev) begin
        if (n > 0) chk({tag, "_gap"}, lo, exp_gap);
        n++; hi = 0; lo = 0;
      end
      if (!b && prev) chk({tag, "_hi"}, hi, exp_hi);
      if (b) hi++; else lo++;
      prev = b;
    end
    if (prev) chk({tag, "_hi_open"}, hi, exp_hi);
    chk({tag, "_n"}, n, exp_n);
  endtask

  initial begin
    tick; tick;
    chk("rst_dir_m0", odir_m0, 0);
    chk("rst_coin_m0", ocoin_m0, 0);
    chk("rst_pend_m0", pend_m0, 0);
    chk("rst_dir_m1", odir_m1, 0);
    chk("rst_dir_m2", odir_m2, 0);
    chk("rst_coin_m12", {ocoin_m1, ocoin_m2}, 0);
    chk("rst_pend_m12", {pend_m1, pend_m2}, 0);
    chk("rst_g0", {odir_g0, ocoin_g0, pend_g0}, 0);
    chk("rst_p4", {odir_p4, ocoin_p4, pend_p4}, 0);
    rst_n = 1'b1;
    tick;

    // Last-press-wins on a single player
    dir_m0 = 4'b0001; tick; tick;
    chk("t1_r", odir_m0, 4'b0001);
    dir_m0 = 4'b0011; tick;
    chk("t1_lat", odir_m0, 4'b0001);
    tick;
    chk("t1_rl", odir_m0, 4'b0010);
    dir_m0 = 4'b0001; tick; tick;
    chk("t1_rel_l", odir_m0, 4'b0001);
    dir_m0 = 4'b1101; tick; tick;
    chk("t1_ud_same", odir_m0, 4'b1001);

    // Neutral and first-press-wins; player 1 presses both at once
    dir2 = 8'h01; tick; tick;
    chk("t2_m1_r", odir_m1, 8'h01);
    chk("t2_m2_r", odir_m2, 8'h01);
    dir2 = 8'h33; tick; tick;
    chk("t2_m1_conf", odir_m1, 8'h00);
    chk("t2_m2_conf", odir_m2, 8'h01);

    // Four players, conflicting directions
    dir_p4 = 16'h4C21; tick; tick;
    chk("t6_dir_a", odir_p4, 16'h4821);
    dir_p4 = 16'hCC33; tick; tick;
    chk("t6_dir_b", odir_p4, 16'h8812);

    // Single coin: latency and pend visibility
    coin_m0 = 1'b1; tick; tick;
    nrec = 0; rec = 1'b1;
    coin_m0 = 1'b0; tick;
    chk("t3_k_pend", pend_m0, 0);
    chk("t3_k_coin", ocoin_m0, 0);
    tick;
    chk("t3_k1_pend", pend_m0, 1);
    chk("t3_k1_coin", ocoin_m0, 0);
    tick;
    chk("t3_k2_coin", ocoin_m0, 1);
    chk("t3_k2_pend", pend_m0, 0);
    repeat (20) tick;
    rec = 1'b0;
    analyze("t3", 0, 1, 8, 0);

    // Five rapid coins (saturation) and, alongside, two coins with no gap state
    nrec = 0; rec = 1'b1;
    for (int i = 0; i < 5; i++) begin
      coin_m0 = 1'b1; coin_g0 = (i < 2); tick;
      coin_m0 = 1'b0; coin_g0 = 1'b0; tick;
    end
    tick;
    chk("t4_pend_sat", pend_m0, 3);
    repeat (50) tick;
    rec = 1'b0;
    analyze("t4", 0, 4, 8, 5);
    analyze("t5_gap0", 1, 2, 8, 1);

    // All four channels coin at once, channel p gets p+1 coins
    nrec = 0; rec = 1'b1;
    for (int i = 0; i < 4; i++) begin
      for (int p = 0; p < 4; p++) coin_p4[p] = (i <= p);
      tick;
      coin_p4 = '0; tick;
    end
    tick;
    chk("t6_pend", pend_p4, 8'hE4);
    repeat (50) tick;
    rec = 1'b0;
    for (int p = 0; p < 4; p++) analyze($sformatf("t6_ch%0d", p), 2 + p, p + 1, 8, 5);

    // Reset mid-pulse with two coins queued, coin held through reset release
    for (int i = 0; i < 3; i++) begin
      coin_m0 = 1'b1; tick;
      coin_m0 = 1'b0; tick;
    end
    tick;
    chk("t5_pre_pend", pend_m0, 2);
    chk("t5_pre_coin", ocoin_m0, 1);
    rst_n = 1'b0; coin_m0 = 1'b1; tick;
    chk("t5_rst_coin", ocoin_m0, 0);
    chk("t5_rst_pend", pend_m0, 0);
    chk("t5_rst_dir", odir_m0, 0);
    tick;
    rst_n = 1'b1;
    nrec = 0; rec = 1'b1;
    repeat (30) tick;
    rec = 1'b0;
    analyze("t5_quiet", 0, 0, 8, 5);
    nrec = 0; rec = 1'b1;
    coin_m0 = 1'b0;
    repeat (20) tick;
    rec = 1'b0;
    analyze("t5_held", 0, 1, 8, 5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
